bf_data_tape: RTL
=================

Name: bf_data_tape

Overview:
- Data-cell memory addressed by the register pointer's R_ADR. It is the responder side of the pointer/tape interface.
- Executes the cell-level Brainfuck operations through an internal read-modify-write sequencer: '+', '-', ',' (load) and '.'/'[' / ']' (read).
- Returns the resulting cell value plus a zero flag. The control unit uses the zero flag for loop decisions.
- Zero-fills every cell automatically after reset.

Parameters:
- ADDR_W, 10, cell address width; must match pointer width.
- DATA_W, 8, cell width in bits.
- DEPTH, 1024, number of cells; fixed at 2**ADDR_W.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- r_adr  input  ADDR_W  cell address from pointer; sampled only on command accept.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  block can accept a command this cycle.
- cmd_op  input  3  000 NOP, 001 INC, 010 DEC, 011 LOAD, 100 READ; 101-111 treated as READ.
- cmd_din  input  DATA_W  value written on LOAD.
- rsp_valid  output  1  one-cycle pulse: result available.
- cell_dout  output  DATA_W  post-operation cell value; held until next response.
- cell_zero  output  1  high when cell_dout == 0; held until next response.
- init_busy  output  1  high during post-reset zero-fill.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n; it may assert at any time.
- Reset values: state=CLEAR, sweep counter=0, cmd_ready=0, rsp_valid=0, cell_dout=0, cell_zero=1, init_busy=1.
- Storage: single-port RAM, DEPTH x DATA_W, with synchronous read (data is valid the cycle after the address is presented).
- States: CLEAR, IDLE, RD, WR, RSP.
- CLEAR:
  - Writes 0 to cell[counter] and increments the counter once per cycle.
  - After writing cell DEPTH-1 it goes to IDLE and deasserts init_busy.
  - Takes DEPTH cycles after reset release. Commands are ignored because cmd_ready=0.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready: latch r_adr, cmd_op and cmd_din, then go to RD. This is the accept cycle, N.
  - With cmd_valid=0, stay in IDLE.
- RD (cycle N+1): present the latched address to the RAM for a read; cmd_ready=0.
- WR (cycle N+2):
  - RAM data d is available. Compute the new value n:
    - INC: n=d+1 modulo 2**DATA_W, so 255->0.
    - DEC: n=d-1 modulo 2**DATA_W, so 0->255.
    - LOAD: n=cmd_din.
    - NOP/READ/undefined codes: n=d.
  - Write n back to the latched address only for INC, DEC and LOAD.
  - Register n into cell_dout and (n==0) into cell_zero.
- RSP (cycle N+3): rsp_valid=1 for exactly this cycle, then go to IDLE.
- Timing: latency from accept to rsp_valid is 3 cycles. Back-to-back throughput is one command per 4 cycles; next accept is earliest at N+4.
- r_adr changes after the accept cycle do not affect the in-flight command.
- Back-to-back operations on the same address see the previous write, with no stale data, because the write in WR completes before the next RD.
- cmd_valid held high while cmd_ready=0: no effect. The command is accepted on the first cycle in IDLE.
- Reset mid-operation:
  - Aborts any RMW. An in-flight write may or may not have completed; the sweep overwrites it anyway.
  - Restarts CLEAR from cell 0 with all outputs at reset values.
- No internal caching of the cell value between commands; every command reads the RAM.

Test Plan:
- Reset release -> init_busy=1 and cmd_ready=0 for 1024 cycles, then init_busy=0 and cmd_ready=1. READ at addresses 0, 511 and 1023 each returns 0 with cell_zero=1.
- INC x3 at address 5 -> responses 1, 2, 3; rsp_valid exactly 3 cycles after each accept; cmd_ready low from accept+1 to accept+3.
- DEC at address 7 on a fresh cell -> 255 and cell_zero=0. Then INC at address 7 -> 0 and cell_zero=1, confirming wrap both ways.
- Isolation between cells: LOAD 0xA5 at address 1023, then READ at address 1022 -> 0; READ at address 1023 -> 0xA5. Changing r_adr in the cycle after accept does not alter the targeted cell.
- Undefined opcodes: cmd_op=110 after LOAD 0x3C at address 2 -> returns 0x3C, and a following READ confirms 0x3C unchanged.
- Reset in the WR cycle of an INC at address 9 -> outputs return to reset values immediately. After the new 1024-cycle sweep, READ at address 9 returns 0.

Source files
------------

// File: rtl/bf_data_tape.sv
// Brainfuck data tape: a DEPTH x DATA_W cell RAM driven by a read-modify-write sequencer.
// Zero-fills every cell after reset, then serves INC/DEC/LOAD/READ commands from the control unit.
module bf_data_tape #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] r_adr,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_din,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] cell_dout,
    output logic              cell_zero,
    output logic              init_busy,
    output logic [2:0]        dbg_state
);

    // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
    // cmd_ready is high only in IDLE, and rsp_valid is a single-cycle pulse with no back-pressure.

    typedef enum logic [2:0] {
        S_CLEAR = 3'd0,
        S_IDLE  = 3'd1,
        S_RD    = 3'd2,
        S_WR    = 3'd3,
        S_RSP   = 3'd4
    } state_t;

    localparam logic [2:0] OP_INC  = 3'b001;
    localparam logic [2:0] OP_DEC  = 3'b010;
    localparam logic [2:0] OP_LOAD = 3'b011;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] clr_cnt;
    logic [ADDR_W-1:0] lat_adr;
    logic [2:0]        lat_op;
    logic [DATA_W-1:0] lat_din;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] ram_q;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_adr;
    logic [DATA_W-1:0] ram_wd;
    logic [DATA_W-1:0] new_val;
    logic              accept;

    assign accept    = cmd_valid && cmd_ready;
    assign dbg_state = state;

    always_comb begin
        new_val = ram_q;
        case (lat_op)
            OP_INC:  new_val = ram_q + DATA_W'(1);
            OP_DEC:  new_val = ram_q - DATA_W'(1);
            OP_LOAD: new_val = lat_din;
            default: new_val = ram_q;
        endcase
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        init_busy = 1'b0;
        ram_we    = 1'b0;
        ram_adr   = lat_adr;
        ram_wd    = new_val;
        case (state)
            S_CLEAR: begin
                init_busy = 1'b1;
                ram_we    = 1'b1;
                ram_adr   = clr_cnt;
                ram_wd    = '0;
                if (clr_cnt == ADDR_W'(DEPTH - 1)) state_nxt = S_IDLE;
            end
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nxt = S_RD;
            end
            S_RD:  state_nxt = S_WR;
            S_WR: begin
                // Read-only opcodes leave the cell untouched.
                ram_we    = (lat_op == OP_INC) || (lat_op == OP_DEC) || (lat_op == OP_LOAD);
                state_nxt = S_RSP;
            end
            S_RSP: begin
                rsp_valid = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_CLEAR;
            clr_cnt   <= '0;
            lat_adr   <= '0;
            lat_op    <= '0;
            lat_din   <= '0;
            cell_dout <= '0;
            cell_zero <= 1'b1;
        end else begin
            state <= state_nxt;
            if (state == S_CLEAR) clr_cnt <= clr_cnt + ADDR_W'(1);
            if (accept) begin
                lat_adr <= r_adr;
                lat_op  <= cmd_op;
                lat_din <= cmd_din;
            end
            if (state == S_WR) begin
                cell_dout <= new_val;
                cell_zero <= (new_val == '0);
            end
        end
    end

    // Single-port RAM with registered read; contents are not reset, the sweep clears them.
    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_adr] <= ram_wd;
        ram_q <= mem[ram_adr];
    end

endmodule
